wb_write_arbiter: RTL
=====================

Name: wb_write_arbiter

Overview:
- Writer-side driver for the 32-entry integer register file.
- Accepts completed results from two producers, the ALU and the load unit, over valid/ready handshakes, and buffers each in its own FIFO.
- Arbitrates round-robin onto the single register-file write port (write_en / write_reg / write_data), issuing at most one write per cycle.
- Sits between the execute/memory stages and the register file.

Parameters:
- WIDTH, 32, data width of a result and of a register.
- REG_BITS, 5, destination register index width.
- DEPTH, 4, entries per source FIFO; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result present
- alu_ready  output  1  ALU FIFO can accept
- alu_rd  input  REG_BITS  ALU destination register
- alu_data  input  WIDTH  ALU result
- mem_valid  input  1  load result present
- mem_ready  output  1  load FIFO can accept
- mem_rd  input  REG_BITS  load destination register
- mem_data  input  WIDTH  load result
- flush  input  1  discard all buffered results
- write_en  output  1  register-file write enable
- write_reg  output  REG_BITS  register-file write index
- write_data  output  WIDTH  register-file write data
- pending  output  1  any FIFO entry held
- lookup_reg  input  REG_BITS  bypass query index (BYPASS_EN only)
- lookup_hit  output  1  query matches a queued or in-flight write
- lookup_data  output  WIDTH  forwarded value

Behaviour:
- Reset (rstn low, asynchronous) clears both FIFOs. All outputs reset to 0, except alu_ready = mem_ready = 1 once rstn is deasserted. last_grant resets to MEM, so the ALU wins the first tie.
- Push: an entry is accepted on a clock edge where valid && ready.
  - ready = FIFO not full, computed from registered occupancy only; no push-through when full, even if a pop happens that cycle.
  - Upstream holds rd and data stable while valid is high and ready is low.
- Pop/arbitrate: each cycle, if exactly one FIFO is non-empty, pop its head. If both are non-empty, pop the source opposite last_grant, then update last_grant.
- Output registers load from the popped head:
  - write_en <= (popped && rd != 0)
  - write_reg / write_data <= the head's rd and data
  - With no pop, write_en <= 0 and write_reg / write_data hold their values.
- Latency: an entry accepted at edge N into an empty FIFO with no competing entry appears on write_en after edge N+1. An entry is never popped in the same cycle it is pushed.
- rd = 0 entries still consume a pop slot but produce write_en = 0.
- Ordering: FIFO order is preserved within a source. Upstream (scoreboard) guarantees that no two in-flight results from different sources target the same rd.
- flush (synchronous) empties both FIFOs at the edge and forces write_en <= 0 that edge. It takes priority over simultaneous pushes and pops, which are dropped. last_grant is unchanged.
- pending = alu FIFO non-empty || mem FIFO non-empty (combinational from occupancy).
- Occupancy counters are REG_BITS-independent, sized $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - lookup_hit / lookup_data are combinational.
  - Search order: youngest matching entry in the ALU FIFO, then youngest in the load FIFO, then the output register when write_en is high. First match wins.
  - lookup_reg = 0 never hits.
- Undefined: lookup_hit = 0 and lookup_data = 0 constantly, and lookup_reg is ignored.

Test Plan:
- Reset: hold rstn low, drive alu_valid=1 -> write_en=0, pending=0. After release, alu_ready=1 and mem_ready=1.
- Single ALU push of rd=5, data=0x0000_00AA at edge N -> write_en=1, write_reg=5, write_data=0xAA after edge N+1. write_en=0 the following cycle.
- Simultaneous ALU (rd=6, 0x11) and mem (rd=11, 0x22) pushes, both FIFOs empty -> ALU write first, then mem on the next cycle. Both pairs repeated -> strict alternation.
- Fill the ALU FIFO with 4 entries while the mem FIFO keeps winning -> alu_ready=0 after the 4th push. A push attempted while full is not accepted. ALU entries drain in order 1..4.
- Push rd=0, data=0xFFFF_FFFF -> no write_en pulse; pending drops after the pop. Then push 2 entries and assert flush -> no writes, pending=0, ready=1.
- WB_BYPASS_EN: queue ALU entries rd=5 with 0x1 then 0x2, and set lookup_reg=5 -> hit=1, data=0x2. After both drain, hit=0. lookup_reg=0 -> hit=0.

Source files
------------

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Purpose  : Write-back driver for the integer register file. Buffers ALU
//            and load-unit results in two independent FIFOs and grants the
//            single register-file write port round-robin, one write per
//            cycle, through registered outputs.
// Ports    : clk, rstn (async active-low)
//            alu_valid/alu_ready/alu_rd/alu_data : ALU result handshake
//            mem_valid/mem_ready/mem_rd/mem_data : load result handshake
//            flush                               : drop all buffered results
//            write_en/write_reg/write_data       : register-file write port
//            pending                             : any result still buffered
//            lookup_reg/lookup_hit/lookup_data   : bypass query
// Options  : WB_BYPASS_EN - enables the combinational bypass lookup; when
//            undefined lookup_hit/lookup_data are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
    parameter int WIDTH    = 32,
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_BITS-1:0] alu_rd,
    input  logic [WIDTH-1:0]    alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic [WIDTH-1:0]    mem_data,
    input  logic                flush,
    output logic                write_en,
    output logic [REG_BITS-1:0] write_reg,
    output logic [WIDTH-1:0]    write_data,
    output logic                pending,
    input  logic [REG_BITS-1:0] lookup_reg,
    output logic                lookup_hit,
    output logic [WIDTH-1:0]    lookup_data
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam int               SRC_ALU   = 0;
    localparam int               SRC_MEM   = 1;
    localparam logic             GRANT_ALU = 1'b0;
    localparam logic             GRANT_MEM = 1'b1;

    // Per-source FIFO storage and state, index 0 = ALU, 1 = load unit
    logic [REG_BITS-1:0] rd_mem_q   [2][DEPTH];
    logic [WIDTH-1:0]    data_mem_q [2][DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q   [2];
    logic [PTR_W-1:0]    rd_ptr_q   [2];
    logic [CNT_W-1:0]    cnt_q      [2];
    logic [CNT_W-1:0]    cnt_d      [2];
    logic                ready_q    [2];

    logic                in_valid   [2];
    logic [REG_BITS-1:0] in_rd      [2];
    logic [WIDTH-1:0]    in_data    [2];
    logic                push       [2];
    logic                pop        [2];
    logic                nonempty   [2];

    logic                last_grant_q, last_grant_d;
    logic                any_pop;
    logic [REG_BITS-1:0] head_rd;
    logic [WIDTH-1:0]    head_data;

    logic                write_en_q;
    logic [REG_BITS-1:0] write_reg_q;
    logic [WIDTH-1:0]    write_data_q;

    assign in_valid[SRC_ALU] = alu_valid;
    assign in_valid[SRC_MEM] = mem_valid;
    assign in_rd[SRC_ALU]    = alu_rd;
    assign in_rd[SRC_MEM]    = mem_rd;
    assign in_data[SRC_ALU]  = alu_data;
    assign in_data[SRC_MEM]  = mem_data;

    // Ready comes from a register loaded with next occupancy, so a full FIFO
    // never accepts a push even when it is being popped in the same cycle.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            nonempty[s] = (cnt_q[s] != '0);
            push[s]     = in_valid[s] && ready_q[s] && !flush;
        end
    end

    // Round-robin only matters under contention; last_grant is touched only
    // when both sources compete.
    always_comb begin
        pop[SRC_ALU] = 1'b0;
        pop[SRC_MEM] = 1'b0;
        last_grant_d = last_grant_q;
        if (!flush) begin
            if (nonempty[SRC_ALU] && nonempty[SRC_MEM]) begin
                if (last_grant_q == GRANT_MEM) begin
                    pop[SRC_ALU] = 1'b1;
                    last_grant_d = GRANT_ALU;
                end else begin
                    pop[SRC_MEM] = 1'b1;
                    last_grant_d = GRANT_MEM;
                end
            end else begin
                pop[SRC_ALU] = nonempty[SRC_ALU];
                pop[SRC_MEM] = nonempty[SRC_MEM];
            end
        end
    end

    always_comb begin
        any_pop   = pop[SRC_ALU] || pop[SRC_MEM];
        head_rd   = pop[SRC_MEM] ? rd_mem_q[SRC_MEM][rd_ptr_q[SRC_MEM]]
                                 : rd_mem_q[SRC_ALU][rd_ptr_q[SRC_ALU]];
        head_data = pop[SRC_MEM] ? data_mem_q[SRC_MEM][rd_ptr_q[SRC_MEM]]
                                 : data_mem_q[SRC_ALU][rd_ptr_q[SRC_ALU]];
        for (int s = 0; s < 2; s++) begin
            if (flush) begin
                cnt_d[s] = '0;
            end else begin
                cnt_d[s] = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
                ready_q[s]  <= 1'b0;
                for (int e = 0; e < DEPTH; e++) begin
                    rd_mem_q[s][e]   <= '0;
                    data_mem_q[s][e] <= '0;
                end
            end
            last_grant_q <= GRANT_MEM;
            write_en_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                cnt_q[s]   <= cnt_d[s];
                ready_q[s] <= (cnt_d[s] != CNT_FULL);
                if (flush) begin
                    wr_ptr_q[s] <= '0;
                    rd_ptr_q[s] <= '0;
                end else begin
                    if (push[s]) begin
                        rd_mem_q[s][wr_ptr_q[s]]   <= in_rd[s];
                        data_mem_q[s][wr_ptr_q[s]] <= in_data[s];
                        wr_ptr_q[s]                <= wr_ptr_q[s] + 1'b1;
                    end
                    if (pop[s]) begin
                        rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
                    end
                end
            end
            last_grant_q <= last_grant_d;
            // r0 entries use up their slot but never write
            write_en_q   <= any_pop && (head_rd != '0);
            if (any_pop) begin
                write_reg_q  <= head_rd;
                write_data_q <= head_data;
            end
        end
    end

    assign alu_ready  = ready_q[SRC_ALU];
    assign mem_ready  = ready_q[SRC_MEM];
    assign write_en   = write_en_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign pending    = nonempty[SRC_ALU] || nonempty[SRC_MEM];

`ifdef WB_BYPASS_EN
    // Candidates are visited lowest priority first (output register, then
    // load FIFO, then ALU FIFO, each oldest to youngest) so the last match
    // assigned is the winning one.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        if (lookup_reg != '0) begin
            if (write_en_q && (write_reg_q == lookup_reg)) begin
                lookup_hit  = 1'b1;
                lookup_data = write_data_q;
            end
            for (int s = SRC_MEM; s >= SRC_ALU; s--) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if ((CNT_W'(i) < cnt_q[s]) &&
                        (rd_mem_q[s][rd_ptr_q[s] + PTR_W'(i)] == lookup_reg)) begin
                        lookup_hit  = 1'b1;
                        lookup_data = data_mem_q[s][rd_ptr_q[s] + PTR_W'(i)];
                    end
                end
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_reg;
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
`endif

endmodule
`default_nettype wire
